// File: rtl/stage_mem_lsu_pkg.sv
// rtl/stage_mem_lsu_pkg.sv - shared encodings for the MEM-stage load/store unit
package stage_mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Number of address bits that select a byte lane within one XLEN word.
    function automatic int lane_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    function automatic int lane_count(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/stage_mem_lsu_align.sv
// rtl/stage_mem_lsu_align.sv - byte-lane select, store shift, load extend, access check
module stage_mem_lsu_align
    import stage_mem_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 op,
    input  logic [lane_bits(XLEN)-1:0] offset,
    input  logic                       force_align,
    input  logic [XLEN-1:0]            store_data,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN/8-1:0]          sel,
    output logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            load_data,
    output logic                       misalign,
    output logic                       illegal
);

    localparam int NB    = lane_count(XLEN);
    localparam int OFF_W = lane_bits(XLEN);

    logic [1:0]       sz;
    logic             sgn;
    logic [OFF_W-1:0] amask;
    logic [OFF_W-1:0] off_eff;
    logic [NB-1:0]    lanes;
    logic [63:0]      sh;
    logic [63:0]      ext;

    always_comb begin
        sz      = 2'd0;
        sgn     = 1'b0;
        illegal = 1'b0;
        case (op)
            F3_B:  begin sz = 2'd0; sgn = 1'b1; end
            F3_H:  begin sz = 2'd1; sgn = 1'b1; end
            F3_W:  begin sz = 2'd2; sgn = 1'b1; end
            F3_BU: begin sz = 2'd0; sgn = 1'b0; end
            F3_HU: begin sz = 2'd1; sgn = 1'b0; end
            F3_D:  begin sz = 2'd3; illegal = (XLEN != 64); end
            F3_WU: begin sz = 2'd2; illegal = (XLEN != 64); end
            default: illegal = 1'b1;
        endcase

        amask    = OFF_W'((4'd1 << sz) - 4'd1);
        misalign = |(offset & amask);
        off_eff  = force_align ? (offset & ~amask) : offset;

        case (sz)
            2'd0:    lanes = NB'(1);
            2'd1:    lanes = NB'(3);
            2'd2:    lanes = NB'(15);
            default: lanes = '1;
        endcase
        sel = lanes << off_eff;

        // Replicating the datum fills every aligned lane, so the selected lane is always correct.
        case (sz)
            2'd0:    wdata = {NB{store_data[7:0]}};
            2'd1:    wdata = {(NB/2){store_data[15:0]}};
            2'd2:    wdata = {(NB/4){store_data[31:0]}};
            default: wdata = store_data;
        endcase

        sh = 64'(rdata) >> {off_eff, 3'b000};
        case (sz)
            2'd0:    ext = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
            2'd1:    ext = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            2'd2:    ext = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            default: ext = sh;
        endcase
        load_data = ext[XLEN-1:0];
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// rtl/stage_mem_lsu.sv - MEM stage with stalling request/acknowledge load/store unit
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       reg_wdata_i,
    input  logic                  mem_rd_i,
    input  logic                  mem_wr_i,
    input  logic [2:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [XLEN-1:0]       store_data_i,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  we_o,
    output logic [XLEN-1:0]       reg_wdata_o,
    output logic                  exc_o,
    output logic                  stall_req,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN/8-1:0]     mem_sel,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int OFF_W = lane_bits(XLEN);

    lsu_state_t state;
    lsu_state_t state_nxt;

    logic [XLEN/8-1:0] al_sel;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_load;
    logic              al_misalign;
    logic              al_illegal;
    logic [XLEN-1:0]   load_q;
    logic              is_mem;
    logic              fault;
    logic              go;

    stage_mem_lsu_align #(.XLEN(XLEN)) u_align (
        .op          (mem_op_i),
        .offset      (mem_addr_i[OFF_W-1:0]),
        .force_align (ALIGN_CHECK == 0),
        .store_data  (store_data_i),
        .rdata       (mem_rdata),
        .sel         (al_sel),
        .wdata       (al_wdata),
        .load_data   (al_load),
        .misalign    (al_misalign),
        .illegal     (al_illegal)
    );

    assign is_mem = valid_i && (mem_rd_i || mem_wr_i);
    assign fault  = is_mem && (al_illegal || (mem_rd_i && mem_wr_i)
                               || ((ALIGN_CHECK != 0) && al_misalign));
    assign go     = is_mem && !fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && go) begin
                mem_req   <= 1'b1;
                mem_we    <= mem_wr_i;
                mem_addr  <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_sel   <= al_sel;
                mem_wdata <= al_wdata;
            end else if (state == ST_REQ && mem_ack) begin
                mem_req <= 1'b0;
                load_q  <= al_load;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        stall_req   = 1'b0;
        exc_o       = 1'b0;
        we_o        = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = reg_wdata_i;
        if (rst) begin
            state_nxt   = ST_IDLE;
            reg_waddr_o = '0;
            reg_wdata_o = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fault) begin
                        exc_o = 1'b1;
                    end else if (go) begin
                        stall_req = 1'b1;
                        state_nxt = ST_REQ;
                    end else begin
                        we_o = valid_i && we_i;
                    end
                end
                ST_REQ: begin
                    stall_req = 1'b1;
                    if (mem_ack) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                    if (mem_rd_i) begin
                        we_o        = we_i;
                        reg_wdata_o = load_q;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// tb/tb_stage_mem_lsu.sv - randomized self-checking bench for stage_mem_lsu
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  reg_waddr_i;
    logic        we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  reg_waddr_o;
    logic        we_o;
    logic [31:0] reg_wdata_o;
    logic        exc_o;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    stage_mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .reg_waddr_i  (reg_waddr_i),
        .we_i         (we_i),
        .reg_wdata_i  (reg_wdata_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .mem_op_i     (mem_op_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .reg_waddr_o  (reg_waddr_o),
        .we_o         (we_o),
        .reg_wdata_o  (reg_wdata_o),
        .exc_o        (exc_o),
        .stall_req    (stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input int off, input logic [31:0] rd);
        int          n;
        logic [63:0] v;
        logic [63:0] m;
        n = op_bytes(op);
        v = {32'd0, rd} >> (8 * off);
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (op[2] == 1'b0 && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        valid_i  = 1'b0;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        we_i     = 1'b0;
    endtask

    task automatic do_alu(input logic [31:0] wd, input logic we, input logic [4:0] wa, input logic ack_noise);
        valid_i = 1'b1; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        reg_wdata_i = wd; we_i = we; reg_waddr_i = wa; mem_ack = ack_noise;
        #1;
        chk("alu_wdata", reg_wdata_o, wd);
        chk("alu_we", we_o, we);
        chk("alu_waddr", reg_waddr_o, wa);
        chk("alu_stall", stall_req, 0);
        chk("alu_exc", exc_o, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("alu_no_req", mem_req, 0);
        idle_inputs();
    endtask

    task automatic do_mem(input logic [2:0] op, input logic is_st, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int waits);
        int          n;
        int          off;
        logic [3:0]  esel;
        logic [31:0] lmask;
        logic [31:0] ewd;
        logic [4:0]  wa;
        logic        we;
        n   = op_bytes(op);
        off = int'(addr[1:0]);
        esel = 4'(((1 << n) - 1) << off);
        lmask = 32'd0;
        ewd   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (esel[i]) begin
                lmask[8*i +: 8] = 8'hFF;
                ewd[8*i +: 8]   = sdata[8*(i-off) +: 8];
            end
        end
        wa = 5'($urandom); we = 1'($urandom);
        valid_i = 1'b1; mem_rd_i = !is_st; mem_wr_i = is_st; mem_op_i = op;
        mem_addr_i = addr; store_data_i = sdata; we_i = we; reg_waddr_i = wa;
        reg_wdata_i = $urandom;
        #1;
        chk("c0_stall", stall_req, 1);
        chk("c0_exc", exc_o, 0);
        chk("c0_we", we_o, 0);
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            chk("req_req", mem_req, 1);
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            chk("req_sel", mem_sel, esel);
            chk("req_we", mem_we, is_st);
            if (is_st) chk("req_wdata", mem_wdata & lmask, ewd);
            chk("req_stall", stall_req, 1);
            if (w == waits) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("done_stall", stall_req, 0);
        chk("done_req", mem_req, 0);
        chk("done_we", we_o, is_st ? 1'b0 : we);
        if (!is_st) chk("done_load", reg_wdata_o, model_load(op, off, rdata));
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("after_stall", stall_req, 0);
    endtask

    task automatic do_fault(input logic [2:0] op, input logic rd, input logic wr, input logic [31:0] addr);
        valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_op_i = op;
        mem_addr_i = addr; we_i = 1'b1; store_data_i = $urandom;
        #1;
        chk("flt_exc", exc_o, 1);
        chk("flt_stall", stall_req, 0);
        chk("flt_we", we_o, 0);
        @(posedge clk); #1;
        chk("flt_no_req", mem_req, 0);
        idle_inputs();
        #1;
        chk("flt_exc_clear", exc_o, 0);
    endtask

    initial begin
        logic [2:0]  lops [5];
        logic [2:0]  sops [3];
        logic [2:0]  bad  [3];
        lops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        sops = '{3'b000, 3'b001, 3'b010};
        bad  = '{3'b011, 3'b110, 3'b111};

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0; mem_op_i = 3'b000;
        mem_addr_i = 32'd0; store_data_i = 32'd0; reg_wdata_i = 32'h5555_5555;
        reg_waddr_i = 5'd7; idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we_bus", mem_we, 0);
        chk("rst_sel", mem_sel, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_we_o", we_o, 0);
        chk("rst_wdata_o", reg_wdata_o, 0);
        chk("rst_waddr_o", reg_waddr_o, 0);
        chk("rst_exc", exc_o, 0);
        chk("rst_stall", stall_req, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        we_i = 1'b1; #1;
        chk("invalid_we", we_o, 0);

        do_alu(32'h0000_1234, 1'b1, 5'd3, 1'b1);
        do_mem(3'b000, 1'b0, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 0);
        do_mem(3'b101, 1'b0, 32'h0000_0202, 32'd0, 32'h8001_0000, 3);
        do_mem(3'b001, 1'b1, 32'h0000_0010, 32'hAAAA_BEEF, 32'd0, 1);
        do_fault(3'b010, 1'b1, 1'b0, 32'h0000_0101);
        do_fault(3'b010, 1'b1, 1'b1, 32'h0000_0100);

        // Abandon an outstanding request with reset, then run a clean load.
        valid_i = 1'b1; mem_rd_i = 1'b1; mem_op_i = 3'b010; mem_addr_i = 32'h40; we_i = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstreq_req", mem_req, 0);
        chk("rstreq_stall", stall_req, 0);
        chk("rstreq_we", we_o, 0);
        chk("rstreq_wdata_o", reg_wdata_o, 0);
        chk("rstreq_sel", mem_sel, 0);
        rst = 1'b0; idle_inputs();
        @(posedge clk); #1;
        do_mem(3'b010, 1'b0, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, 0);

        for (int it = 0; it < 60; it++) begin
            int          kind;
            int          n;
            logic [2:0]  op;
            logic [31:0] a;
            @(posedge clk); #1;
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if (kind == 0) begin
                do_alu($urandom, 1'($urandom), 5'($urandom), 1'($urandom));
            end else if (kind == 1 || kind == 2) begin
                op = (kind == 1) ? lops[$urandom_range(0, 4)] : sops[$urandom_range(0, 2)];
                n  = op_bytes(op);
                a[1:0] = 2'(n * $urandom_range(0, (4 / n) - 1));
                do_mem(op, kind == 2, a, $urandom, $urandom, $urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0: do_fault(bad[$urandom_range(0, 2)], 1'b1, 1'b0, {a[31:2], 2'b00});
                    1: do_fault(3'b010, 1'($urandom), 1'b1, {a[31:2], 2'($urandom_range(1, 3))});
                    default: do_fault(3'b001, 1'b1, 1'b0, {a[31:2], 1'($urandom), 1'b1});
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
Parametrised pipeline MEM stage for the RISC-V core, replacing the pass-through MEM stage. ALU/control results pass straight through to writeback. Loads and stores run a request/acknowledge transaction on the data-memory port and hold the pipeline with stall_req until the transaction completes. Adds byte-lane selection, load sign/zero extension, misalignment detection and optional RV64 widths.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ADDR_W, 32, memory address width
REG_ADDR_W, 5, register-file address width
ALIGN_CHECK, 1, 1 = misaligned accesses raise exc_o and issue no bus request; 0 = address low bits ignored (forced aligned)

Ports:
clk  in  1  clock
rst  in  1  reset; rst, synchronous, active-high
valid_i  in  1  instruction in MEM is valid
reg_waddr_i  in  REG_ADDR_W  destination register
we_i  in  1  register write enable from EX
reg_wdata_i  in  XLEN  ALU result (non-load)
mem_rd_i  in  1  instruction is a load
mem_wr_i  in  1  instruction is a store
mem_op_i  in  3  funct3 access type
mem_addr_i  in  ADDR_W  effective address
store_data_i  in  XLEN  rs2 value for stores
reg_waddr_o  out  REG_ADDR_W  to MEM/WB register
we_o  out  1  write enable to WB
reg_wdata_o  out  XLEN  result to WB
exc_o  out  1  misaligned or illegal-width access, one cycle
stall_req  out  1  hold all upstream stages
mem_req  out  1  bus request (registered)
mem_we  out  1  bus write
mem_sel  out  XLEN/8  byte-lane enables
mem_addr  out  ADDR_W  bus address, aligned to XLEN/8
mem_wdata  out  XLEN  lane-shifted store data
mem_ack  in  1  bus completion, one-cycle pulse
mem_rdata  in  XLEN  load data, valid with mem_ack

Behaviour:
- Reset: state IDLE; mem_req, mem_we, mem_sel, mem_addr, mem_wdata, load-data register = 0; reg_waddr_o = 0, we_o = 0, reg_wdata_o = 0, exc_o = 0, stall_req = 0 while rst is high.
- mem_op_i: 000 B, 001 H, 010 W, 100 BU, 101 HU. With XLEN=64 only: 011 D, 110 WU. Any other code is illegal.
- Non-memory op (valid_i, neither mem_rd_i nor mem_wr_i): pass-through with zero added latency, as in the previous stage; stall_req = 0.
- valid_i = 0: we_o = 0, no request.
- mem_rd_i and mem_wr_i both high: treated as illegal.
- Misaligned means the address is not a multiple of the access size. When the op is misaligned or illegal (ALIGN_CHECK=1), or illegal (ALIGN_CHECK=0):
  - exc_o = 1 and we_o = 0 for that cycle;
  - no bus request; stall_req = 0.
- FSM, state IDLE:
  - Legal memory op present: stall_req = 1 combinationally.
  - Next state REQ. At that edge register mem_req = 1, mem_we = mem_wr_i, mem_addr = addr with the low log2(XLEN/8) bits cleared, mem_sel, mem_wdata.
- FSM, state REQ:
  - stall_req = 1; all bus outputs held stable.
  - On the edge where mem_ack = 1: mem_req clears, the formatted load data is captured, next state DONE.
  - mem_ack seen in IDLE or DONE is ignored.
- FSM, state DONE:
  - stall_req = 0.
  - Load: we_o = we_i, reg_wdata_o = captured data.
  - Store: we_o = 0.
  - Next state IDLE, so the downstream register latches this cycle.
- Upstream inputs are stable throughout, because the stall holds them.
- Latency: with mem_ack in the first REQ cycle, op enters in cycle 0, stall_req is high for cycles 0–1, and the result appears in cycle 2. Every extra wait cycle adds one cycle.
- mem_sel / mem_wdata: for a lane offset o = addr mod (XLEN/8) and access size n bytes:
  - sel = ((1<<n)-1) << o;
  - wdata = store_data_i low n bytes shifted left by 8*o (store data replicated across the other lanes is acceptable).
- Load extraction: take n bytes from mem_rdata starting at offset o.
  - B, H, W (XLEN=64): sign-extend to XLEN.
  - BU, HU, WU: zero-extend to XLEN.
- rst during REQ: the request is abandoned; mem_req = 0 on the next cycle and the state returns to IDLE. The bus slave must tolerate an abandoned request.

Decomposition:
- Shared package (defines): mem_op funct3 encodings, FSM state encoding (IDLE/REQ/DONE), XLEN-derived lane-count constants.
- Sub-module lsu_align (combinational):
  - Inputs: op, address offset, store data, read data.
  - Outputs: sel, shifted wdata, extended load data, misalign/illegal flag.
  - Reused by a future instruction-fetch or AMO unit.

Test Plan:
- ALU op, reg_wdata_i=0x1234 and we_i=1 -> same cycle reg_wdata_o=0x1234, we_o=1, stall_req=0, mem_req never set.
- LB at addr 0x103, mem_rdata=0x80FF_FFFF, ack on first REQ cycle -> mem_addr=0x100, mem_sel=4'b1000, stall_req high for 2 cycles, reg_wdata_o=0xFFFF_FF80.
- LHU at addr 0x202, mem_rdata=0x8001_0000, ack after 3 wait cycles -> mem_sel=4'b1100, stall_req high for 5 cycles, reg_wdata_o=0x0000_8001.
- SH at addr 0x10, store_data_i=0xAAAA_BEEF -> mem_we=1, mem_sel=4'b0011, mem_wdata[15:0]=0xBEEF, we_o=0 in DONE.
- LW at addr 0x101 with ALIGN_CHECK=1 -> exc_o=1 for one cycle, mem_req stays 0, stall_req=0, we_o=0.
- rst pulsed while in REQ with no ack -> next cycle mem_req=0, stall_req=0, all outputs 0; a following LW completes normally.
